ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
Iterative multiply/divide unit for the RV32M extension. It sits directly downstream of the ID/EX pipeline register, inside the execute stage. It consumes the latched instruction's funct3, both source register values and the destination register address. It returns a write-back result after a multi-cycle computation and raises a busy flag that the execute stage forwards to ctrl as a pipeline hold request.

Parameters:
- DATA_W, 32: operand/result width; the iteration count equals DATA_W.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle request; the current ID/EX outputs carry an M-extension op
- op_i  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- op1_i  in  DATA_W  rs1 value (multiplicand / dividend)
- op2_i  in  DATA_W  rs2 value (multiplier / divisor)
- reg_waddr_i  in  5  destination register address
- flush_i  in  1  jump/interrupt flush from ctrl; abort any operation
- result_o  out  DATA_W  final result
- ready_o  out  1  result valid this cycle; one-cycle pulse
- reg_we_o  out  1  GPR write enable; equals ready_o
- reg_waddr_o  out  5  destination register address latched at start
- busy_o  out  1  unit occupied; execute stage ORs this with start_i to form its hold request

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, counter 0. result_o, reg_waddr_o and all internal registers are 0; ready_o, reg_we_o and busy_o are 0. Reset mid-operation discards the operation with no ready pulse.
- States:
  - IDLE: accept start_i.
  - CALC: one iteration per cycle.
  - DONE: present the result.
- busy_o = (state != IDLE). ready_o = reg_we_o = (state == DONE) && !flush_i.
- IDLE, start_i=1, flush_i=0: latch op, reg_waddr and operands; set sign flags.
  - Special division cases go straight to DONE with the result loaded; ready is high in the cycle after start.
  - All other ops go to CALC with counter=0.
- Operand preparation:
  - Signed operands are converted to magnitudes: MUL/MULH both signed; MULHSU op1 signed only; DIV/REM both signed; all others unsigned.
- CALC, multiply: radix-2 shift-add into a 2*DATA_W accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; the remainder register is DATA_W+1 bits.
- CALC runs exactly DATA_W cycles (counter 0..DATA_W-1), then moves to DONE.
  - Normal-op latency: start sampled at edge N, ready high during the cycle after edge N+DATA_W+1 (33 edges for DATA_W=32).
- Result fix-up on entering DONE:
  - Product negated if the operand signs differ. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Special cases (no iteration):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op1_i.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- DONE lasts exactly one cycle, then IDLE. result_o and reg_waddr_o hold their values until the next load.
- start_i while busy_o=1 is ignored; the execute stage must not issue one.
- flush_i=1 in any state: next state IDLE with no ready pulse. flush_i beats start_i when both are high in the same cycle. A flush during DONE suppresses ready_o/reg_we_o combinationally in that cycle.
- Back-to-back: start_i may be accepted in the cycle immediately after DONE.

Decomposition:
- Shared defines file: funct3 codes for the eight M-ops (INST_MUL … INST_REMU), plus existing ZeroWord, ZeroReg, WriteEnable/WriteDisable.
- State encodings (3 states, one-hot or binary) stay local to the block.
- No sub-module is required. Magnitude/negate logic is a local function, shared by the operand preparation and fix-up steps.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB with ready_o pulse 33 edges after start; reg_waddr_o equals the latched address; busy_o high through DONE.
- op1=op2=0xFFFFFFFF with MULHU, MULH, MULHSU -> 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF respectively.
- DIV/REM op1=0xFFFFFFF9 (-7), op2=2 -> 0xFFFFFFFD / 0xFFFFFFFF; DIVU/REMU op1=100, op2=7 -> 14 / 2.
- Divide by zero op1=5, op2=0: DIV -> 0xFFFFFFFF, REM -> 5, ready one cycle after start. Overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
- DIVU started, flush_i pulsed at CALC cycle 10 -> no ready pulse, busy_o=0 next cycle. A new MUL 3*4 then returns 12. Same check with rst=0 mid-CALC, plus a start_i while busy that is ignored.
- flush_i during the DONE cycle -> ready_o=reg_we_o=0. start_i and flush_i together in IDLE -> remains IDLE.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared RV32M definitions for the execute-stage multiply/divide unit.
// funct3 codes, write-enable levels and operand-sign decode helpers.
package ex_mdu_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [31:0] ZeroWord     = 32'h0;
  localparam logic [4:0]  ZeroReg      = 5'h0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op1_signed(input logic [2:0] op);
    return (op == INST_MUL)
        || (op == INST_MULH)
        || (op == INST_MULHSU)
        || (op == INST_DIV)
        || (op == INST_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] op);
    return (op == INST_MUL)
        || (op == INST_MULH)
        || (op == INST_DIV)
        || (op == INST_REM);
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit in the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o,
  output logic              busy_o
);

  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [W2-1:0] neg_if(
    input logic [W2-1:0] v,
    input logic           neg
  );
    return neg ? (~v + W2'(1)) : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;

  logic              s1, s2;
  logic              div0, ovf;
  logic [W2-1:0]     mag1_w, mag2_w;
  logic [W2-1:0]     prod_fix, quo_fix, rem_fix;
  logic [DATA_W:0]   sum;
  logic [DATA_W+1:0] trial, diff;
  logic              unused_ok;

  assign s1 = op1_signed(op_i) & op1_i[DATA_W-1];
  assign s2 = op2_signed(op_i) & op2_i[DATA_W-1];

  assign mag1_w = neg_if({{DATA_W{1'b0}}, op1_i}, s1);
  assign mag2_w = neg_if({{DATA_W{1'b0}}, op2_i}, s2);

  assign div0 = is_div(op_i) && (op2_i == '0);
  assign ovf  = ((op_i == INST_DIV) || (op_i == INST_REM))
             && (op1_i == {1'b1, {(DATA_W-1){1'b0}}})
             && (op2_i == '1);

  assign sum = {1'b0, acc_q[W2-1:DATA_W]}
             + (acc_q[0] ? {1'b0, opb_q} : '0);

  assign trial = {rem_q, quo_q[DATA_W-1]};
  assign diff  = trial - {2'b00, opb_q};

  assign prod_fix = neg_if(acc_q, neg_res_q);
  assign quo_fix  = neg_if({{DATA_W{1'b0}}, quo_q}, neg_res_q);
  assign rem_fix  = neg_if({{DATA_W{1'b0}}, rem_q[DATA_W-1:0]}, neg_rem_q);

  assign unused_ok = ^{mag1_w[W2-1:DATA_W], mag2_w[W2-1:DATA_W],
                       quo_fix[W2-1:DATA_W], rem_fix[W2-1:DATA_W]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    waddr_d   = waddr_q;
    result_d  = result_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_d      = op_i;
            waddr_d   = reg_waddr_i;
            neg_res_d = s1 ^ s2;
            neg_rem_d = s1;
            cnt_d     = '0;
            unique case (1'b1)
              div0: begin
                result_d = op_i[1] ? op1_i : '1;
                state_d  = S_DONE;
              end
              ovf: begin
                result_d = op_i[1] ? '0 : op1_i;
                state_d  = S_DONE;
              end
              default: begin
                acc_d   = {{DATA_W{1'b0}}, mag2_w[DATA_W-1:0]};
                opb_d   = is_div(op_i) ? mag2_w[DATA_W-1:0]
                                       : mag1_w[DATA_W-1:0];
                quo_d   = mag1_w[DATA_W-1:0];
                rem_d   = '0;
                state_d = S_CALC;
              end
            endcase
          end
        end
        S_CALC: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            // all bits consumed; apply sign fix-up from settled registers
            if (is_div(op_q))
              result_d = op_q[1] ? rem_fix[DATA_W-1:0]
                                 : quo_fix[DATA_W-1:0];
            else if (op_q == INST_MUL)
              result_d = prod_fix[DATA_W-1:0];
            else
              result_d = prod_fix[W2-1:DATA_W];
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_div(op_q)) begin
              quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W+1]};
              rem_d = diff[DATA_W+1] ? trial[DATA_W:0] : diff[DATA_W:0];
            end else begin
              acc_d = {sum, acc_q[DATA_W-1:1]};
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      waddr_q   <= ZeroReg;
      result_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      waddr_q   <= waddr_d;
      result_q  <= result_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign ready_o     = (state_q == S_DONE) && !flush_i;
  assign reg_we_o    = ready_o ? WriteEnable : WriteDisable;
  assign result_o    = result_q;
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed-vector bench for ex_mdu.
// Hand-computed RV32M results, latency, flush and reset behaviour.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        busy_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  ex_mdu #(.DATA_W(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive start across edge N; returns #1 after edge N
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] wa);
    @(negedge clk);
    start_i     = 1'b1;
    op_i        = op;
    op1_i       = a;
    op2_i       = b;
    reg_waddr_i = wa;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready_o && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // count ready pulses over n cycles
  task automatic watch_quiet(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] wa,
                        input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    issue(op, a, b, wa);
    wait_ready(lat);
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_wa"}, {27'd0, reg_waddr_o}, {27'd0, wa});
    chk({tag, "_we"}, {31'd0, reg_we_o}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {30'd0, busy_o, ready_o}, 32'd0);
    chk({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    int lat;
    int seen;
    rst         = 1'b0;
    start_i     = 1'b0;
    flush_i     = 1'b0;
    op_i        = 3'd0;
    op1_i       = 32'd0;
    op2_i       = 32'd0;
    reg_waddr_i = 5'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", result_o, 32'd0);
    chk("rst_wa", {27'd0, reg_waddr_o}, 32'd0);
    chk("rst_flags", {29'd0, ready_o, reg_we_o, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul", INST_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5,
           32'hFFFF_FFEB, 33);
    run_op("mulhu", INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
           32'hFFFF_FFFE, 33);
    run_op("mulh", INST_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
           32'h0000_0000, 33);
    run_op("mulhsu", INST_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,
           32'hFFFF_FFFF, 33);
    run_op("div", INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9,
           32'hFFFF_FFFD, 33);
    run_op("rem", INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd10,
           32'hFFFF_FFFF, 33);
    run_op("divu", INST_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    run_op("remu", INST_REMU, 32'd100, 32'd7, 5'd12, 32'd2, 33);
    run_op("div0", INST_DIV, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 0);
    run_op("rem0", INST_REM, 32'd5, 32'd0, 5'd14, 32'd5, 0);
    run_op("divu0", INST_DIVU, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, 0);
    run_op("remu0", INST_REMU, 32'd9, 32'd0, 5'd16, 32'd9, 0);
    run_op("dovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17,
           32'h8000_0000, 0);
    run_op("rovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18,
           32'd0, 0);
    run_op("mulneg", INST_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 5'd19,
           32'd30, 33);

    // flush mid-CALC
    issue(INST_DIVU, 32'd1000, 32'd3, 5'd20);
    watch_quiet(10, seen);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("fl_busy", {31'd0, busy_o}, 32'd0);
    watch_quiet(40, seen);
    chk("fl_noready", seen, 32'd0);
    chk("fl_hold", result_o, 32'd30);
    run_op("fl_mul", INST_MUL, 32'd3, 32'd4, 5'd21, 32'd12, 33);

    // reset mid-CALC
    issue(INST_MULHU, 32'hFFFF_FFFF, 32'h1234_5678, 5'd22);
    watch_quiet(5, seen);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rs_busy", {31'd0, busy_o}, 32'd0);
    chk("rs_res", result_o, 32'd0);
    chk("rs_wa", {27'd0, reg_waddr_o}, 32'd0);
    watch_quiet(40, seen);
    chk("rs_noready", seen, 32'd0);

    // start while busy is ignored
    issue(INST_MUL, 32'd3, 32'd4, 5'd7);
    lat = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    issue(INST_DIVU, 32'd100, 32'd7, 5'd9);
    lat++;
    while (!ready_o && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bz_res", result_o, 32'd12);
    chk("bz_wa", {27'd0, reg_waddr_o}, 32'd7);
    chk("bz_lat", lat, 32'd33);
    watch_quiet(40, seen);
    chk("bz_noextra", seen, 32'd0);

    // flush during DONE
    issue(INST_DIV, 32'd5, 32'd0, 5'd23);
    flush_i = 1'b1;
    #1;
    chk("fd_ready", {31'd0, ready_o}, 32'd0);
    chk("fd_we", {31'd0, reg_we_o}, 32'd0);
    chk("fd_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("fd_idle", {31'd0, busy_o}, 32'd0);

    // start and flush together in IDLE
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = INST_MUL;
    op1_i   = 32'd6;
    op2_i   = 32'd6;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("sf_busy", {31'd0, busy_o}, 32'd0);
    watch_quiet(40, seen);
    chk("sf_noready", seen, 32'd0);

    run_op("b2b_a", INST_REMU, 32'd17, 32'd5, 5'd24, 32'd2, 33);
    run_op("b2b_b", INST_DIVU, 32'd17, 32'd5, 5'd25, 32'd3, 33);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
